key_debounce_rep: RTL and testbench

// Conditions one raw push-button input for the counter lab datapath. The block has three stages:
// a 2-FF synchroniser, a stable-time debounce FSM, and an optional auto-repeat timer.
// It produces a debounced level, single-cycle press and release strobes, and periodic

---
 rtl/key_debounce_rep.sv | 142 ++++++++++++++
 tb/tb_key_debounce_rep.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_rep.sv
// Push-button conditioner: 2-FF synchroniser, stable-time debounce FSM and hold-to-repeat timer.
// All outputs are registered; strobes are one cycle wide.
module key_debounce_rep #(
    parameter int ACTIVE_LOW = 1,
    parameter int DEB_CYCLES = 100000,
    parameter int REP_DELAY  = 50000000,
    parameter int REP_PERIOD = 10000000
) (
    input  logic clk100_i,
    input  logic rst_i,
    input  logic key_i,
    input  logic rep_en_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic rep_o
);

    localparam int DW   = $clog2(DEB_CYCLES);
    localparam int RMAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int RW   = $clog2(RMAX);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REP_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REP_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   deb_q, deb_d;
    logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
    logic            periodic_q, periodic_d;
    logic            sync1_q, sync2_q;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            rel_q, rel_d;
    logic            rep_q, rep_d;
    logic            raw_p;
    logic            p;

    // Normalise before synchronising so reset can load the "released" level for either polarity.
    assign raw_p = (ACTIVE_LOW != 0) ? ~key_i : key_i;
    assign p     = sync2_q;

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_p;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            deb_q      <= '0;
            rep_cnt_q  <= '0;
            periodic_q <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            rel_q      <= 1'b0;
            rep_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            deb_q      <= deb_d;
            rep_cnt_q  <= rep_cnt_d;
            periodic_q <= periodic_d;
            level_q    <= level_d;
            press_q    <= press_d;
            rel_q      <= rel_d;
            rep_q      <= rep_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        deb_d      = deb_q;
        rep_cnt_d  = rep_cnt_q;
        periodic_d = periodic_q;
        press_d    = 1'b0;
        rel_d      = 1'b0;
        rep_d      = 1'b0;
        case (state_q)
            IDLE: begin
                rep_cnt_d  = '0;
                periodic_d = 1'b0;
                if (p) begin
                    state_d = PRESS_CHK;
                    deb_d   = '0;
                end
            end
            PRESS_CHK: begin
                if (!p) begin
                    state_d = IDLE;
                end else if (deb_q == DEB_LAST) begin
                    state_d    = HELD;
                    press_d    = 1'b1;
                    rep_cnt_d  = '0;
                    periodic_d = 1'b0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            HELD: begin
                if (!p) begin
                    state_d = REL_CHK;
                    deb_d   = '0;
                end
                if (!rep_en_i) begin
                    rep_cnt_d  = '0;
                    periodic_d = 1'b0;
                end else if (rep_cnt_q == (periodic_q ? PER_LAST : DLY_LAST)) begin
                    rep_d      = 1'b1;
                    rep_cnt_d  = '0;
                    periodic_d = 1'b1;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end
            REL_CHK: begin
                // Repeat timer is left untouched here so a bounce resumes the schedule.
                if (p) begin
                    state_d = HELD;
                end else if (deb_q == DEB_LAST) begin
                    state_d = IDLE;
                    rel_d   = 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        level_d = (state_d == HELD) || (state_d == REL_CHK);
    end

    assign level_o   = level_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign rep_o     = rep_q;

endmodule

// File: tb/tb_key_debounce_rep.sv
// Bench for key_debounce_rep: directed key waveforms, expected strobes queued with their cycle,
// a monitor per instance pops and compares whenever a strobe appears.
module tb_key_debounce_rep;

    localparam logic [2:0] K_PRESS = 3'b001;
    localparam logic [2:0] K_REL   = 3'b010;
    localparam logic [2:0] K_REP   = 3'b100;

    typedef struct {
        logic [2:0] kind;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst, key1, key2, rep_en;
    logic level1, press1, rel1, rep1;
    logic level2, press2, rel2, rep2;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    ev_t  q1[$];
    ev_t  q2[$];

    key_debounce_rep #(.ACTIVE_LOW(1), .DEB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(3)) dut1 (
        .clk100_i(clk), .rst_i(rst), .key_i(key1), .rep_en_i(rep_en),
        .level_o(level1), .press_o(press1), .release_o(rel1), .rep_o(rep1)
    );

    key_debounce_rep #(.ACTIVE_LOW(0), .DEB_CYCLES(4), .REP_DELAY(10), .REP_PERIOD(3)) dut2 (
        .clk100_i(clk), .rst_i(rst), .key_i(key2), .rep_en_i(1'b0),
        .level_o(level2), .press_o(press2), .release_o(rel2), .rep_o(rep2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic exp_level(input logic [2:0] k);
        return (k != K_REL);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            while (q1.size() > 0 && q1[0].cyc < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL dut1_missing: strobe %b expected at cycle %0d, not seen by %0d",
                         q1[0].kind, q1[0].cyc, cyc);
                void'(q1.pop_front());
            end
            if (press1 || rel1 || rep1) begin
                n_chk++;
                if (q1.size() == 0 || q1[0].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL dut1_unexpected: strobes {rep,rel,press}=%b at cycle %0d, none required",
                             {rep1, rel1, press1}, cyc);
                end else begin
                    ev_t e;
                    e = q1.pop_front();
                    if ({rep1, rel1, press1} != e.kind || level1 != exp_level(e.kind)) begin
                        n_fail++;
                        $display("FAIL dut1_strobe: cycle %0d got strobes %b level %b, want %b level %b",
                                 cyc, {rep1, rel1, press1}, level1, e.kind, exp_level(e.kind));
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            while (q2.size() > 0 && q2[0].cyc < cyc) begin
                n_chk++; n_fail++;
                $display("FAIL dut2_missing: strobe %b expected at cycle %0d, not seen by %0d",
                         q2[0].kind, q2[0].cyc, cyc);
                void'(q2.pop_front());
            end
            if (press2 || rel2 || rep2) begin
                n_chk++;
                if (q2.size() == 0 || q2[0].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL dut2_unexpected: strobes {rep,rel,press}=%b at cycle %0d, none required",
                             {rep2, rel2, press2}, cyc);
                end else begin
                    ev_t e;
                    e = q2.pop_front();
                    if ({rep2, rel2, press2} != e.kind || level2 != exp_level(e.kind)) begin
                        n_fail++;
                        $display("FAIL dut2_strobe: cycle %0d got strobes %b level %b, want %b level %b",
                                 cyc, {rep2, rel2, press2}, level2, e.kind, exp_level(e.kind));
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chk_all_zero1(input string nm);
        chk({nm, "_level"}, level1, 1'b0);
        chk({nm, "_press"}, press1, 1'b0);
        chk({nm, "_release"}, rel1, 1'b0);
        chk({nm, "_rep"}, rep1, 1'b0);
    endtask

    task automatic push1(input logic [2:0] k, input int c);
        ev_t e;
        e.kind = k; e.cyc = c;
        q1.push_back(e);
    endtask

    task automatic push2(input logic [2:0] k, input int c);
        ev_t e;
        e.kind = k; e.cyc = c;
        q2.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the bench just after a falling edge such that the next rising edge is edge e.
    task automatic step_to(input int e);
        while (cyc + 1 < e) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int p;
        rst = 1'b1; key1 = 1'b1; key2 = 1'b0; rep_en = 1'b0;
        step(3);
        chk_all_zero1("reset1");
        chk("reset2_level", level2, 1'b0);
        chk("reset2_press", press2, 1'b0);
        rst = 1'b0;
        step(3);

        // clean press: first sampled at edge N, strobe after edge N+6
        key1 = 1'b0; push1(K_PRESS, cyc + 7);
        step(12);
        chk("clean_level_held", level1, 1'b1);
        key1 = 1'b1; push1(K_REL, cyc + 7);
        step(10);
        chk("clean_level_released", level1, 1'b0);

        // active-high key on the second instance, same timing
        key2 = 1'b1; push2(K_PRESS, cyc + 7);
        step(12);
        chk("pol_level_held", level2, 1'b1);
        key2 = 1'b0; push2(K_REL, cyc + 7);
        step(10);
        chk("pol_level_released", level2, 1'b0);

        // 3-cycle glitch rejected
        key1 = 1'b0; step(3); key1 = 1'b1;
        step(10);
        chk("glitch3_level", level1, 1'b0);

        // 5-cycle pulse accepted, release 6 cycles after the rising edge
        key1 = 1'b0; push1(K_PRESS, cyc + 7);
        step(5);
        key1 = 1'b1; push1(K_REL, cyc + 7);
        step(12);

        // auto-repeat: reps at +10,+13,...,+25; key released so it leaves HELD before +28
        rep_en = 1'b1;
        key1 = 1'b0; p = cyc + 7;
        push1(K_PRESS, p);
        for (int k = 10; k <= 25; k += 3) push1(K_REP, p + k);
        step_to(p + 24);
        key1 = 1'b1; push1(K_REL, p + 30);
        step(12);

        // repeat disabled: press and release only
        rep_en = 1'b0;
        key1 = 1'b0; p = cyc + 7;
        push1(K_PRESS, p);
        step(30);
        key1 = 1'b1; push1(K_REL, cyc + 7);
        step(12);

        // release bounce: 2 high cycles freeze the repeat timer, schedule slips by 2
        rep_en = 1'b1;
        key1 = 1'b0; p = cyc + 7;
        push1(K_PRESS, p);
        push1(K_REP, p + 12);
        push1(K_REP, p + 15);
        push1(K_REP, p + 18);
        step_to(p + 3);
        key1 = 1'b1; step(2); key1 = 1'b0;
        step_to(p + 7);
        chk("bounce_level", level1, 1'b1);
        step_to(p + 17);
        key1 = 1'b1; push1(K_REL, p + 23);
        step(12);
        rep_en = 1'b0;

        // reset during PRESS_CHK, key kept pressed
        key1 = 1'b0;
        step(4);
        #2 rst = 1'b1;
        #1 chk_all_zero1("rst_presschk");
        step(2);
        rst = 1'b0; push1(K_PRESS, cyc + 7);
        step(10);
        chk("pre_rst_held_level", level1, 1'b1);
        // reset during HELD: level drops at once, no release strobe follows
        #2 rst = 1'b1;
        #1 chk_all_zero1("rst_held");
        step(1);
        rst = 1'b0; push1(K_PRESS, cyc + 7);
        step(10);
        chk("post_rst_level", level1, 1'b1);
        key1 = 1'b1; push1(K_REL, cyc + 7);
        step(12);

        n_chk++;
        if (q1.size() != 0) begin
            n_fail++;
            $display("FAIL dut1_drain: %0d expected strobes outstanding, want 0", q1.size());
        end
        n_chk++;
        if (q2.size() != 0) begin
            n_fail++;
            $display("FAIL dut2_drain: %0d expected strobes outstanding, want 0", q2.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
